regfile_wb_scheduler: RTL and testbench

//  Schedules the register file's single write port between two write-back sources:
//   the ALU result path and the memory-load return path.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/wb_rr_arbiter.sv | 45 ++++
 rtl/regfile_wb_scheduler.sv | 105 ++++++++++
 tb/tb_regfile_wb_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file write-back scheduler.
package regfile_pkg;

   localparam int DW   = 33;
   localparam int MW   = 34;
   localparam int AW   = 5;
   localparam int NREG = 2 ** AW;

   typedef logic [AW-1:0] reg_addr_t;
   typedef logic [DW-1:0] reg_data_t;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } wb_src_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter between the ALU and load-return write-back sources.
// A lone eligible source always wins.
// On a tie the source that did not win the previous tie is granted.
module wb_rr_arbiter
   import regfile_pkg::*;
(
   input  logic clk,
   input  logic rstN,
   input  logic aluElig,
   input  logic memElig,
   output logic aluWin,
   output logic memWin
);

   wb_src_e rrLast;
   logic    tie;

   assign tie = aluElig & memElig;

   // Grant decision: rrLast only breaks ties, it never blocks a lone requester.
   always_comb begin
      aluWin = 1'b0;
      memWin = 1'b0;
      if (tie) begin
         if (rrLast == SRC_MEM) begin
            aluWin = 1'b1;
         end else begin
            memWin = 1'b1;
         end
      end else begin
         aluWin = aluElig;
         memWin = memElig;
      end
   end

   // Remember who won the last tie; reset favours the ALU on the first tie.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rrLast <= SRC_MEM;
      end else if (tie) begin
         rrLast <= aluWin ? SRC_ALU : SRC_MEM;
      end
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Schedules the single register-file write port between ALU results and load returns,
// keeps a per-register pending-load scoreboard and raises the decode read-hazard stall.
module regfile_wb_scheduler
   import regfile_pkg::*;
(
   input  logic            FAS,
   input  logic            nRST,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [AW-1:0]   alu_addr,
   input  logic [DW-1:0]   alu_data,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [AW-1:0]   mem_addr,
   input  logic [MW-1:0]   mem_data,
   input  logic            ld_issue,
   input  logic [AW-1:0]   ld_issue_addr,
   input  logic [AW-1:0]   rd_addr_n,
   input  logic [AW-1:0]   rd_addr_s,
   input  logic [AW-1:0]   rd_addr_m,
   output logic            stall,
   output logic            wr_en,
   output logic [AW-1:0]   wr_addr,
   output logic [DW-1:0]   wr_data,
   output logic [NREG-1:0] pending,
   output logic            sb_err
);

   logic            aluElig;
   logic            memElig;
   logic            aluWin;
   logic            memWin;
   logic [NREG-1:0] pendingNext;
   reg_data_t       memDataTrunc;
   logic            unusedMemHigh;

   // Only the low DW bits of load data reach the register file.
   assign memDataTrunc  = mem_data[DW-1:0];
   assign unusedMemHigh = ^mem_data[MW-1:DW];

   // An ALU write to a register with an older load in flight must wait (WAW ordering).
   assign aluElig = alu_valid & ~pending[alu_addr];
   assign memElig = mem_valid;

   wb_rr_arbiter uArbiter (
      .clk     (FAS),
      .rstN    (nRST),
      .aluElig (aluElig),
      .memElig (memElig),
      .aluWin  (aluWin),
      .memWin  (memWin)
   );

   assign alu_ready = aluWin;
   assign mem_ready = memWin;

   // Write stage: capture the winner for one cycle; address and data hold when idle.
   always_ff @(posedge FAS or negedge nRST) begin
      if (!nRST) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else if (aluWin) begin
         wr_en   <= 1'b1;
         wr_addr <= alu_addr;
         wr_data <= alu_data;
      end else if (memWin) begin
         wr_en   <= 1'b1;
         wr_addr <= mem_addr;
         wr_data <= memDataTrunc;
      end else begin
         wr_en   <= 1'b0;
      end
   end

   // Scoreboard update: clear on load return, then set on issue so a new load wins.
   always_comb begin
      pendingNext = pending;
      if (memWin) begin
         pendingNext[mem_addr] = 1'b0;
      end
      if (ld_issue) begin
         pendingNext[ld_issue_addr] = 1'b1;
      end
   end

   // Scoreboard register and sticky double-issue error flag.
   always_ff @(posedge FAS or negedge nRST) begin
      if (!nRST) begin
         pending <= '0;
         sb_err  <= 1'b0;
      end else begin
         pending <= pendingNext;
         if (ld_issue && pending[ld_issue_addr]) begin
            sb_err <= 1'b1;
         end
      end
   end

   // Without a bypass, decode holds on a pending load or a write still in the write stage.
   assign stall = pending[rd_addr_n] | (wr_en & (wr_addr == rd_addr_n)) |
                  pending[rd_addr_s] | (wr_en & (wr_addr == rd_addr_s)) |
                  pending[rd_addr_m] | (wr_en & (wr_addr == rd_addr_m));

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed, table-driven bench for the register-file write-back scheduler.
module tb_regfile_wb_scheduler;

   logic        FAS;
   logic        nRST;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_addr;
   logic [32:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_addr;
   logic [33:0] mem_data;
   logic        ld_issue;
   logic [4:0]  ld_issue_addr;
   logic [4:0]  rd_addr_n;
   logic [4:0]  rd_addr_s;
   logic [4:0]  rd_addr_m;
   logic        stall;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [32:0] wr_data;
   logic [31:0] pending;
   logic        sb_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        aluValid;
      logic [4:0]  aluAddr;
      logic [32:0] aluData;
      logic        memValid;
      logic [4:0]  memAddr;
      logic [33:0] memData;
      logic        ldIssue;
      logic [4:0]  ldAddr;
      logic [4:0]  rdN;
      logic [4:0]  rdS;
      logic [4:0]  rdM;
      logic        expAluRdy;
      logic        expMemRdy;
      logic        expStall;
      logic        expWrEn;
      logic [4:0]  expWrAddr;
      logic [32:0] expWrData;
      logic [31:0] expPend;
      logic        expSbErr;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vecs [NVEC];

   regfile_wb_scheduler dut (
      .FAS           (FAS),
      .nRST          (nRST),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_addr      (alu_addr),
      .alu_data      (alu_data),
      .mem_valid     (mem_valid),
      .mem_ready     (mem_ready),
      .mem_addr      (mem_addr),
      .mem_data      (mem_data),
      .ld_issue      (ld_issue),
      .ld_issue_addr (ld_issue_addr),
      .rd_addr_n     (rd_addr_n),
      .rd_addr_s     (rd_addr_s),
      .rd_addr_m     (rd_addr_m),
      .stall         (stall),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .pending       (pending),
      .sb_err        (sb_err)
   );

   // Free-running clock, 10 time-unit period.
   initial FAS = 1'b0;
   always #5 FAS = ~FAS;

   function automatic vec_t mk(
      input logic av, input logic [4:0] aa, input logic [32:0] ad,
      input logic mv, input logic [4:0] ma, input logic [33:0] md,
      input logic li, input logic [4:0] la,
      input logic [4:0] rn, input logic [4:0] rs, input logic [4:0] rm,
      input logic ear, input logic emr, input logic est,
      input logic ewe, input logic [4:0] ewa, input logic [32:0] ewd,
      input logic [31:0] ep, input logic esb);
      vec_t v;
      v.aluValid = av;  v.aluAddr = aa;  v.aluData = ad;
      v.memValid = mv;  v.memAddr = ma;  v.memData = md;
      v.ldIssue  = li;  v.ldAddr  = la;
      v.rdN = rn;  v.rdS = rs;  v.rdM = rm;
      v.expAluRdy = ear;  v.expMemRdy = emr;  v.expStall = est;
      v.expWrEn = ewe;  v.expWrAddr = ewa;  v.expWrData = ewd;
      v.expPend = ep;  v.expSbErr = esb;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      alu_valid     = v.aluValid;
      alu_addr      = v.aluAddr;
      alu_data      = v.aluData;
      mem_valid     = v.memValid;
      mem_addr      = v.memAddr;
      mem_data      = v.memData;
      ld_issue      = v.ldIssue;
      ld_issue_addr = v.ldAddr;
      rd_addr_n     = v.rdN;
      rd_addr_s     = v.rdS;
      rd_addr_m     = v.rdM;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic idleInputs();
      alu_valid = 1'b0;  alu_addr = 5'd0;  alu_data = 33'd0;
      mem_valid = 1'b0;  mem_addr = 5'd0;  mem_data = 34'd0;
      ld_issue  = 1'b0;  ld_issue_addr = 5'd0;
      rd_addr_n = 5'd31; rd_addr_s = 5'd31; rd_addr_m = 5'd31;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " wr_en"},   {63'd0, wr_en},   64'd0);
      checkOutput({tag, " wr_addr"}, {59'd0, wr_addr}, 64'd0);
      checkOutput({tag, " wr_data"}, {31'd0, wr_data}, 64'd0);
      checkOutput({tag, " pending"}, {32'd0, pending}, 64'd0);
      checkOutput({tag, " sb_err"},  {63'd0, sb_err},  64'd0);
   endtask

   initial begin
      localparam logic       N = 1'b0;
      localparam logic       Y = 1'b1;
      localparam logic [4:0] R = 5'd31;

      // Cycle-by-cycle script: inputs for one cycle, comb outputs before the edge,
      // registered outputs after it. rd addresses default to 31, never written.
      vecs[0]  = mk(Y,5'd3,33'd87, N,5'd0,34'd0,  N,5'd0, R,R,R, Y,N,N, Y,5'd3,33'd87, 32'h0,N);
      vecs[1]  = mk(N,5'd0,33'd0,  N,5'd0,34'd0,  N,5'd0, R,R,R, N,N,N, N,5'd3,33'd87, 32'h0,N);
      vecs[2]  = mk(Y,5'd2,33'd5,  Y,5'd6,34'd94, N,5'd0, R,R,R, Y,N,N, Y,5'd2,33'd5,  32'h0,N);
      vecs[3]  = mk(N,5'd0,33'd0,  Y,5'd6,34'd94, N,5'd0, R,R,R, N,Y,N, Y,5'd6,33'd94, 32'h0,N);
      vecs[4]  = mk(Y,5'd2,33'd5,  Y,5'd6,34'd94, N,5'd0, R,R,R, N,Y,N, Y,5'd6,33'd94, 32'h0,N);
      vecs[5]  = mk(Y,5'd2,33'd5,  N,5'd0,34'd0,  N,5'd0, R,R,R, Y,N,N, Y,5'd2,33'd5,  32'h0,N);
      vecs[6]  = mk(N,5'd0,33'd0,  N,5'd0,34'd0,  Y,5'd6, R,R,R, N,N,N, N,5'd2,33'd5,  32'h40,N);
      vecs[7]  = mk(Y,5'd6,33'd11, N,5'd0,34'd0,  N,5'd0, R,R,R, N,N,N, N,5'd2,33'd5,  32'h40,N);
      vecs[8]  = mk(Y,5'd6,33'd11, Y,5'd6,34'd63, N,5'd0, R,R,R, N,Y,N, Y,5'd6,33'd63, 32'h0,N);
      vecs[9]  = mk(Y,5'd6,33'd11, N,5'd0,34'd0,  N,5'd0, R,R,R, Y,N,N, Y,5'd6,33'd11, 32'h0,N);
      vecs[10] = mk(N,5'd0,33'd0,  N,5'd0,34'd0,  Y,5'd2, R,R,R, N,N,N, N,5'd6,33'd11, 32'h4,N);
      vecs[11] = mk(N,5'd0,33'd0,  N,5'd0,34'd0,  N,5'd0, R,5'd2,R, N,N,Y, N,5'd6,33'd11, 32'h4,N);
      vecs[12] = mk(Y,5'd4,33'd9,  N,5'd0,34'd0,  N,5'd0, R,R,R, Y,N,N, Y,5'd4,33'd9,  32'h4,N);
      vecs[13] = mk(N,5'd0,33'd0,  N,5'd0,34'd0,  N,5'd0, R,R,5'd4, N,N,Y, N,5'd4,33'd9, 32'h4,N);
      vecs[14] = mk(N,5'd0,33'd0,  N,5'd0,34'd0,  N,5'd0, R,R,5'd4, N,N,N, N,5'd4,33'd9, 32'h4,N);
      vecs[15] = mk(N,5'd0,33'd0,  Y,5'd5,34'd34, Y,5'd5, R,R,R, N,Y,N, Y,5'd5,33'd34, 32'h24,N);
      vecs[16] = mk(N,5'd0,33'd0,  N,5'd0,34'd0,  Y,5'd1, R,R,R, N,N,N, N,5'd5,33'd34, 32'h26,N);
      vecs[17] = mk(N,5'd0,33'd0,  N,5'd0,34'd0,  Y,5'd1, R,R,R, N,N,N, N,5'd5,33'd34, 32'h26,Y);
      vecs[18] = mk(N,5'd0,33'd0,  Y,5'd0,34'h2_0000_0007, N,5'd0, R,R,R, N,Y,N, Y,5'd0,33'd7, 32'h26,Y);
      vecs[19] = mk(N,5'd0,33'd0,  N,5'd0,34'd0,  N,5'd0, 5'd0,R,R, N,N,Y, N,5'd0,33'd7, 32'h26,Y);

      // Power-on reset.
      idleInputs();
      nRST = 1'b0;
      #2;
      checkResetState("por");
      @(negedge FAS);
      nRST = 1'b1;

      // Table-driven main sequence.
      for (int i = 0; i < NVEC; i++) begin
         @(negedge FAS);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("v%0d alu_ready", i), {63'd0, alu_ready}, {63'd0, vecs[i].expAluRdy});
         checkOutput($sformatf("v%0d mem_ready", i), {63'd0, mem_ready}, {63'd0, vecs[i].expMemRdy});
         checkOutput($sformatf("v%0d stall", i),     {63'd0, stall},     {63'd0, vecs[i].expStall});
         @(posedge FAS);
         #1;
         checkOutput($sformatf("v%0d wr_en", i),   {63'd0, wr_en},   {63'd0, vecs[i].expWrEn});
         checkOutput($sformatf("v%0d wr_addr", i), {59'd0, wr_addr}, {59'd0, vecs[i].expWrAddr});
         checkOutput($sformatf("v%0d wr_data", i), {31'd0, wr_data}, {31'd0, vecs[i].expWrData});
         checkOutput($sformatf("v%0d pending", i), {32'd0, pending}, {32'd0, vecs[i].expPend});
         checkOutput($sformatf("v%0d sb_err", i),  {63'd0, sb_err},  {63'd0, vecs[i].expSbErr});
      end

      // Asynchronous reset in the middle of a write, with pending and sb_err set.
      @(negedge FAS);
      idleInputs();
      alu_valid = 1'b1;  alu_addr = 5'd7;  alu_data = 33'd3;
      @(posedge FAS);
      #1;
      checkOutput("mid wr_en before reset", {63'd0, wr_en}, 64'd1);
      #2;
      alu_valid = 1'b0;
      nRST = 1'b0;
      #1;
      checkResetState("async");
      @(negedge FAS);
      nRST = 1'b1;

      // After reset the first tie goes to the ALU; the loser holds and is served next,
      // even though both target the same register.
      @(negedge FAS);
      alu_valid = 1'b1;  alu_addr = 5'd9;  alu_data = 33'd1;
      mem_valid = 1'b1;  mem_addr = 5'd9;  mem_data = 34'd2;
      #1;
      checkOutput("tie alu_ready", {63'd0, alu_ready}, 64'd1);
      checkOutput("tie mem_ready", {63'd0, mem_ready}, 64'd0);
      @(posedge FAS);
      #1;
      checkOutput("tie wr_data alu", {31'd0, wr_data}, 64'd1);
      @(negedge FAS);
      alu_valid = 1'b0;
      #1;
      checkOutput("held mem_ready", {63'd0, mem_ready}, 64'd1);
      @(posedge FAS);
      #1;
      checkOutput("held wr_addr", {59'd0, wr_addr}, 64'd9);
      checkOutput("held wr_data", {31'd0, wr_data}, 64'd2);

      @(negedge FAS);
      idleInputs();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
